// File: rtl/imm_enc_pkg.sv
// Shared types and helpers for the rotated-immediate encoder.
// A rotation step is two bit positions; rot_t holds the 4-bit rotate field.
package imm_enc_pkg;

   localparam int ROT_STEPS = 16;

   typedef logic [3:0] rot_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Rotate left by amt (0..31); the doubled word keeps the wrap free of special cases.
   function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] amt);
      logic [63:0] dbl;
      dbl = {v, v} << amt;
      return dbl[63:32];
   endfunction

endpackage

// File: rtl/imm_rot_lane.sv
// One combinational rotation candidate.
// Undoes the shifter's ROR by 2*r and reports whether the result fits in 8 bits.
module imm_rot_lane
   import imm_enc_pkg::*;
(
   input  logic [31:0] value,
   input  rot_t        r,
   output logic        hit,
   output logic [7:0]  imm8
);

   logic [31:0] rotated_s;

   assign rotated_s = rol32(value, {r, 1'b0});
   assign hit       = (rotated_s[31:8] == 24'd0);
   assign imm8      = rotated_s[7:0];

endmodule

// File: rtl/imm_rot_encoder.sv
// Finds the canonical (lowest rotation) imm8/rot form of a 32-bit constant,
// testing LANES rotations per cycle behind valid/ready handshakes.
module imm_rot_encoder
   import imm_enc_pkg::*;
#(
   parameter int LANES = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        found,
   output logic [7:0]  imm8,
   output logic [3:0]  rot
);

   state_t      state_r;
   logic [31:0] value_r;
   rot_t        rot_cnt_r;
   logic        out_valid_r;
   logic        found_r;
   logic [7:0]  imm8_r;
   rot_t        rot_r;

   logic [LANES-1:0] hit_s;
   logic [7:0]       lane_imm8_s [LANES];
   rot_t             lane_r_s    [LANES];
   logic             any_hit_s;
   logic [7:0]       sel_imm8_s;
   rot_t             sel_rot_s;
   logic             last_group_s;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_r_s[i] = rot_cnt_r + rot_t'(i);

      imm_rot_lane u_lane (
         .value (value_r),
         .r     (lane_r_s[i]),
         .hit   (hit_s[i]),
         .imm8  (lane_imm8_s[i])
      );
   end

   // Lowest-index hit wins: walk from the top so lower lanes overwrite higher ones.
   always_comb begin
      any_hit_s  = 1'b0;
      sel_imm8_s = 8'd0;
      sel_rot_s  = 4'd0;
      for (int i = LANES - 1; i >= 0; i--) begin
         any_hit_s  = any_hit_s | hit_s[i];
         sel_imm8_s = hit_s[i] ? lane_imm8_s[i] : sel_imm8_s;
         sel_rot_s  = hit_s[i] ? lane_r_s[i]    : sel_rot_s;
      end
   end

   assign last_group_s = (({1'b0, rot_cnt_r} + 5'(LANES)) == 5'(ROT_STEPS));
   assign in_ready     = (state_r == IDLE);

   // Control FSM and result registers; results hold in DONE until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         value_r     <= 32'd0;
         rot_cnt_r   <= 4'd0;
         out_valid_r <= 1'b0;
         found_r     <= 1'b0;
         imm8_r      <= 8'd0;
         rot_r       <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  value_r   <= value;
                  rot_cnt_r <= 4'd0;
                  state_r   <= SEARCH;
               end
            end
            SEARCH: begin
               if (any_hit_s) begin
                  found_r     <= 1'b1;
                  imm8_r      <= sel_imm8_s;
                  rot_r       <= sel_rot_s;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else if (last_group_s) begin
                  found_r     <= 1'b0;
                  imm8_r      <= 8'd0;
                  rot_r       <= 4'd0;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  rot_cnt_r <= rot_cnt_r + 4'(LANES);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign found     = found_r;
   assign imm8      = imm8_r;
   assign rot       = rot_r;

endmodule
